// File: rtl/prod_accum.sv
// prod_accum: accumulates a frame of unsigned multiplier products and presents
// the frame sum, beat count and overflow flag through a valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_prod/in_last valid this cycle
//   in_ready   : a beat is accepted this cycle (low while a result is held)
//   in_prod    : unsigned product word from the multiplier stage
//   in_last    : final beat of the current frame
//   out_valid  : frame result is valid
//   out_ready  : downstream consumer takes the result
//   out_sum    : frame sum modulo 2^ACC_WD
//   out_count  : number of beats in the frame
//   out_ovf    : at least one carry out of ACC_WD occurred during the frame
module prod_accum #(
    parameter int unsigned MDMR_WD   = 25,
    parameter int unsigned ACC_WD    = 32,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned CNT_WD    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MDMR_WD-1:0]  in_prod,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_WD-1:0]   out_sum,
    output logic [CNT_WD-1:0]   out_count,
    output logic                out_ovf
);

    localparam int unsigned SUM_WD = ACC_WD + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_WD-1:0]   acc_q, acc_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic                accept;
    logic [SUM_WD-1:0]   sum_ext;
    logic [CNT_WD-1:0]   cnt_inc;

    // Next-state, datapath and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        accept      = in_valid && in_ready_q;
        // Extra top bit captures the carry out of the ACC_WD-bit addition
        sum_ext     = {1'b0, acc_q} + SUM_WD'(in_prod);
        cnt_inc     = cnt_q + CNT_WD'(1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d = ACC_WD'(in_prod);
                    cnt_d = CNT_WD'(1);
                    ovf_d = 1'b0;
                    if (in_last || (CNT_WD'(1) == CNT_WD'(MAX_BEATS))) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = sum_ext[ACC_WD-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum_ext[ACC_WD];
                    // Forced close once the frame reaches MAX_BEATS
                    if (in_last || (cnt_inc == CNT_WD'(MAX_BEATS))) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags follow the state being entered
        in_ready_d  = (state_d != S_HOLD);
        out_valid_d = (state_d == S_HOLD);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL have parameter MDMR_WD, default 25, meaning the width of the unsigned product word received from the 16x9 multiplier stage.
REQ-002 The block SHALL have parameter ACC_WD, default 32, meaning the accumulator and result width; legal range is ACC_WD >= MDMR_WD.
REQ-003 The block SHALL have parameter MAX_BEATS, default 256, meaning the maximum number of products in one frame.
REQ-004 The block SHALL have parameter CNT_WD, default 9, meaning the beat-count width; it SHALL satisfy 2^CNT_WD > MAX_BEATS.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port in_valid, input, 1 bit: in_prod/in_last are valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 Port in_prod, input, MDMR_WD bits: unsigned product (A*B) from the multiplier stage.
REQ-010 Port in_last, input, 1 bit: the beat is the final product of the current frame.
REQ-011 Port out_valid, output, 1 bit: the frame result is valid.
REQ-012 Port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-013 Port out_sum, output, ACC_WD bits: the frame sum modulo 2^ACC_WD.
REQ-014 Port out_count, output, CNT_WD bits: the number of beats in the frame.
REQ-015 Port out_ovf, output, 1 bit: at least one carry out of ACC_WD occurred during the frame.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE (no beats accepted yet), ACC (frame open), and HOLD (result presented).
REQ-017 A beat is accepted only when in_valid and in_ready are both 1 on the same clock edge; in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-018 When a beat is accepted in IDLE, the block SHALL load acc=zero-extended in_prod, cnt=1, and ovf=0, discarding any previous frame contents.
REQ-019 When a beat is accepted in ACC, the block SHALL set acc=acc+in_prod (ACC_WD-bit wrap), increment cnt by 1, and set ovf=ovf OR the carry out of that addition.
REQ-020 The transition IDLE->ACC SHALL occur on an accepted beat with in_last=0 and cnt+1 < MAX_BEATS.
REQ-021 The transition to HOLD (from IDLE or ACC) SHALL occur on an accepted beat where in_last=1 or the new cnt equals MAX_BEATS (forced close); that beat is included in the result.
REQ-022 The latency SHALL be one cycle: out_valid=1 starting the cycle after the closing beat is accepted.
REQ-023 In HOLD, out_sum, out_count and out_ovf SHALL remain stable and out_valid SHALL stay 1 until out_ready=1.
REQ-024 On out_valid AND out_ready, the block SHALL go HOLD->IDLE, and out_valid=0 and in_ready=1 on the next cycle; there is no same-cycle accept in HOLD.
REQ-025 out_sum, out_count and out_ovf SHALL be driven from registers; outside HOLD their values are don't-care but SHALL not be X after reset.
REQ-026 In IDLE or ACC, out_ready SHALL be ignored.
REQ-027 In ACC with in_valid=0, all state SHALL be held; the frame stays open indefinitely.
REQ-028 Sustained input SHALL be accepted at one beat per cycle within a frame; there is at least one bubble cycle between frames.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear acc, cnt and ovf to 0, giving out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 from the next cycle.
REQ-030 A reset asserted in ACC or HOLD SHALL discard the partial or pending frame with no output, and reset SHALL take priority over any simultaneous handshake.

Verification
REQ-031 Apply beats 10, 20, 30 back-to-back with in_last on the third and out_ready=1 -> one cycle later out_sum=60, out_count=3, out_ovf=0, out_valid held for 1 cycle.
REQ-032 Apply a single beat 0x1FFFE01 with in_last=1 from IDLE -> out_sum=0x01FFFE01, out_count=1, out_ovf=0.
REQ-033 Apply 129 beats of 33488385 (65535*511), last on the 129th -> out_sum=25034369, out_count=129, out_ovf=1.
REQ-034 Apply 256 beats of value 1 with in_last never set -> forced close, out_sum=256, out_count=256, and in_ready=0 the cycle after the 256th beat.
REQ-035 Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no beats lost; raise out_ready -> next frame starts fresh, e.g. 7 with last -> out_sum=7.
REQ-036 Assert rst_n=0 for one cycle after beats 5 and 6 in ACC, then send 9 with last -> out_sum=9, out_count=1.
